// File: rtl/scandoubler_pkg.sv
// Shared constants, the packed pixel type and a small counter helper
// used by the scan doubler and its line buffer.
package scandoubler_pkg;

  localparam int SD_ADDR_W    = 9;
  localparam int SD_DEPTH     = 512;
  localparam int SD_HSYNC_LEN = 54;
  localparam int SD_MIN_LEN   = 64;

  typedef struct packed {
    logic [1:0] g;
    logic [1:0] r;
    logic [1:0] b;
  } rgb6_t;

  // Increment that sticks at the all-ones value instead of wrapping.
  function automatic logic [SD_ADDR_W-1:0] sat_inc(input logic [SD_ADDR_W-1:0] v);
    return (v == '1) ? v : v + SD_ADDR_W'(1);
  endfunction

endpackage

// File: rtl/scandoubler_linebuf.sv
// Two-bank line buffer: one write port and one synchronous read port,
// both on clk28. The top address bit selects the bank. Contents are not
// reset; the top module masks banks that hold no data yet.
module scandoubler_linebuf
  import scandoubler_pkg::*;
(
  input  logic                 clk28,
  input  logic                 wr_en,
  input  logic [SD_ADDR_W:0]   wr_addr,
  input  rgb6_t                wr_data,
  input  logic                 rd_en,
  input  logic [SD_ADDR_W:0]   rd_addr,
  output rgb6_t                rd_data
);

  rgb6_t mem [2*SD_DEPTH];
  rgb6_t rd_data_q;

  // Write port: store one pixel per input strobe.
  always_ff @(posedge clk28) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Read port: registered output, updated only on read strobes.
  always_ff @(posedge clk28) begin
    if (rd_en) rd_data_q <= mem[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/scandoubler.sv
// Scan doubler: writes each 15 kHz source line into one bank of the line
// buffer while the other bank is read out twice at double pixel rate.
// In passthrough mode the source is simply registered once.
module scandoubler
  import scandoubler_pkg::*;
#(
  parameter int HSYNC_LEN = SD_HSYNC_LEN,
  parameter int MIN_LEN   = SD_MIN_LEN
) (
  input  logic       clk28,
  input  logic       rst_n,
  input  logic       en,
  input  logic       ck7,
  input  logic       ck14,
  input  logic [1:0] r_in,
  input  logic [1:0] g_in,
  input  logic [1:0] b_in,
  input  logic       hsync_in,
  input  logic       vsync_in,
  output logic [1:0] r,
  output logic [1:0] g,
  output logic [1:0] b,
  output logic       hsync,
  output logic       vsync
);

  localparam logic [SD_ADDR_W-1:0] HSYNC_W = SD_ADDR_W'(HSYNC_LEN);
  localparam logic [SD_ADDR_W:0]   MIN_W   = (SD_ADDR_W+1)'(MIN_LEN);
  localparam logic [SD_ADDR_W:0]   DEPTH_W = (SD_ADDR_W+1)'(SD_DEPTH);

  logic                 hs_in_q, hs_in_d;
  logic                 wr_bank_q, wr_bank_d;
  logic [SD_ADDR_W-1:0] wr_cnt_q, wr_cnt_d;
  logic [SD_ADDR_W:0]   line_len_q, line_len_d;
  logic [SD_ADDR_W-1:0] rd_cnt_q, rd_cnt_d;
  logic                 en_r_q, en_r_d;
  logic                 vs_lat_q, vs_lat_d;
  logic [1:0]           valid_q, valid_d;
  logic                 rd_strobe_q, rd_strobe_d;
  logic                 rd_ok_q, rd_ok_d;
  logic                 rd_hs_q, rd_hs_d;
  rgb6_t                out_q, out_d;
  logic                 hsync_q, hsync_d;
  logic                 vsync_q, vsync_d;

  logic                 line_start;
  logic                 wr_bank_sel;
  logic [SD_ADDR_W-1:0] wr_addr;
  logic                 rd_bank;
  rgb6_t                pix_in;
  rgb6_t                rd_data;

  assign line_start  = hs_in_q & ~hsync_in;
  assign wr_bank_sel = line_start ? ~wr_bank_q : wr_bank_q;
  assign wr_addr     = line_start ? '0 : wr_cnt_q;
  assign rd_bank     = ~wr_bank_q;
  assign pix_in      = {g_in, r_in, b_in};

  scandoubler_linebuf u_linebuf (
    .clk28   (clk28),
    .wr_en   (ck7),
    .wr_addr ({wr_bank_sel, wr_addr}),
    .wr_data (pix_in),
    .rd_en   (ck14),
    .rd_addr ({rd_bank, rd_cnt_q}),
    .rd_data (rd_data)
  );

  // Write side: pixel counter, bank swap, line length and per-line samples of en/vsync.
  always_comb begin
    hs_in_d    = hsync_in;
    wr_bank_d  = wr_bank_q;
    wr_cnt_d   = wr_cnt_q;
    line_len_d = line_len_q;
    en_r_d     = en_r_q;
    vs_lat_d   = vs_lat_q;
    valid_d    = valid_q;
    if (ck7) valid_d[wr_bank_sel] = 1'b1;
    if (line_start) begin
      wr_bank_d  = ~wr_bank_q;
      wr_cnt_d   = {{(SD_ADDR_W-1){1'b0}}, ck7};
      line_len_d = ({1'b0, wr_cnt_q} < MIN_W) ? DEPTH_W : {1'b0, wr_cnt_q};
      en_r_d     = en;
      vs_lat_d   = vsync_in;
    end else if (ck7) begin
      wr_cnt_d = sat_inc(wr_cnt_q);
    end
  end

  // Read side: wrapping read counter and first pipeline stage (valid mask, doubled hsync).
  always_comb begin
    rd_cnt_d    = rd_cnt_q;
    rd_strobe_d = ck14;
    rd_ok_d     = rd_ok_q;
    rd_hs_d     = rd_hs_q;
    if (line_start) begin
      rd_cnt_d = '0;
    end else if (ck14) begin
      rd_cnt_d = ({1'b0, rd_cnt_q} == line_len_q - (SD_ADDR_W+1)'(1)) ? '0 : rd_cnt_q + SD_ADDR_W'(1);
    end
    if (ck14) begin
      rd_ok_d = valid_q[rd_bank];
      rd_hs_d = (rd_cnt_q >= HSYNC_W);
    end
  end

  // Output register: doubled pipeline data or the source delayed by one clock.
  always_comb begin
    out_d   = out_q;
    hsync_d = hsync_q;
    vsync_d = vsync_q;
    if (en_r_q) begin
      if (rd_strobe_q) begin
        out_d   = rd_ok_q ? rd_data : '0;
        hsync_d = rd_hs_q;
      end
      vsync_d = vs_lat_q;
    end else begin
      out_d   = pix_in;
      hsync_d = hsync_in;
      vsync_d = vsync_in;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      hs_in_q     <= 1'b1;
      wr_bank_q   <= 1'b0;
      wr_cnt_q    <= '0;
      line_len_q  <= DEPTH_W;
      rd_cnt_q    <= '0;
      en_r_q      <= 1'b0;
      vs_lat_q    <= 1'b1;
      valid_q     <= '0;
      rd_strobe_q <= 1'b0;
      rd_ok_q     <= 1'b0;
      rd_hs_q     <= 1'b1;
      out_q       <= '0;
      hsync_q     <= 1'b1;
      vsync_q     <= 1'b1;
    end else begin
      hs_in_q     <= hs_in_d;
      wr_bank_q   <= wr_bank_d;
      wr_cnt_q    <= wr_cnt_d;
      line_len_q  <= line_len_d;
      rd_cnt_q    <= rd_cnt_d;
      en_r_q      <= en_r_d;
      vs_lat_q    <= vs_lat_d;
      valid_q     <= valid_d;
      rd_strobe_q <= rd_strobe_d;
      rd_ok_q     <= rd_ok_d;
      rd_hs_q     <= rd_hs_d;
      out_q       <= out_d;
      hsync_q     <= hsync_d;
      vsync_q     <= vsync_d;
    end
  end

  assign r     = out_q.r;
  assign g     = out_q.g;
  assign b     = out_q.b;
  assign hsync = hsync_q;
  assign vsync = vsync_q;

endmodule

// File: tb/tb_scandoubler.sv
// Bench for the scan doubler: line-based stimulus with random pixels and
// vsync, compared every clock against a behavioural model built from
// per-bank pixel arrays and modular read positions.
module tb_scandoubler;

  localparam int HSYNC_LEN = 54;
  localparam int MIN_LEN   = 64;

  logic       clk28 = 1'b0;
  logic       rst_n, en, ck7, ck14, hsync_in, vsync_in;
  logic [1:0] r_in, g_in, b_in;
  logic [1:0] r, g, b;
  logic       hsync, vsync;

  int checks   = 0;
  int failures = 0;
  int gcyc     = 0;

  // model state
  int mem [2][512];
  bit m_valid [2];
  bit m_hs_prev, m_wbank, m_mode, m_vlat;
  int m_wcnt, m_len, m_reads;
  bit pend_ok, pend_hs;
  int pend_rgb;
  int exp_rgb;
  bit exp_hs, exp_vs;

  scandoubler dut (
    .clk28    (clk28),
    .rst_n    (rst_n),
    .en       (en),
    .ck7      (ck7),
    .ck14     (ck14),
    .r_in     (r_in),
    .g_in     (g_in),
    .b_in     (b_in),
    .hsync_in (hsync_in),
    .vsync_in (vsync_in),
    .r        (r),
    .g        (g),
    .b        (b),
    .hsync    (hsync),
    .vsync    (vsync)
  );

  always #5 clk28 = ~clk28;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed != expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, observed, expected, gcyc);
    end
  endtask

  task automatic modelReset();
    m_hs_prev  = 1'b1;
    m_wbank    = 1'b0;
    m_mode     = 1'b0;
    m_vlat     = 1'b1;
    m_wcnt     = 0;
    m_len      = 512;
    m_reads    = 0;
    m_valid[0] = 1'b0;
    m_valid[1] = 1'b0;
    pend_ok    = 1'b0;
    pend_hs    = 1'b1;
    pend_rgb   = 0;
    exp_rgb    = 0;
    exp_hs     = 1'b1;
    exp_vs     = 1'b1;
  endtask

  // Predicts the DUT state right after the next rising edge from the inputs just driven.
  task automatic modelStep();
    bit ls;
    int addr, rb, wb, wa, pix;
    ls  = m_hs_prev && !hsync_in;
    pix = int'({g_in, r_in, b_in});
    if (m_mode) begin
      if (pend_ok) begin
        exp_rgb = pend_rgb;
        exp_hs  = pend_hs;
      end
      exp_vs = m_vlat;
    end else begin
      exp_rgb = pix;
      exp_hs  = hsync_in;
      exp_vs  = vsync_in;
    end
    pend_ok = ck14;
    if (ck14) begin
      addr     = m_reads % m_len;
      rb       = m_wbank ? 0 : 1;
      pend_rgb = m_valid[rb] ? mem[rb][addr] : 0;
      pend_hs  = (addr >= HSYNC_LEN);
      m_reads++;
    end
    if (ck7) begin
      if (ls) wb = m_wbank ? 0 : 1;
      else    wb = m_wbank ? 1 : 0;
      wa = ls ? 0 : ((m_wcnt > 511) ? 511 : m_wcnt);
      mem[wb][wa] = pix;
      m_valid[wb] = 1'b1;
    end
    if (ls) begin
      m_len   = (m_wcnt < MIN_LEN) ? 512 : ((m_wcnt > 511) ? 511 : m_wcnt);
      m_wcnt  = ck7 ? 1 : 0;
      m_wbank = !m_wbank;
      m_reads = 0;
      m_mode  = en;
      m_vlat  = vsync_in;
    end else if (ck7) begin
      m_wcnt++;
    end
    m_hs_prev = hsync_in;
  endtask

  task automatic compareAll();
    if (exp_rgb >= 0) checkOutput("rgb", int'({g, r, b}), exp_rgb);
    checkOutput("hsync", int'(hsync), int'(exp_hs));
    checkOutput("vsync", int'(vsync), int'(exp_vs));
    checkOutput("wr_cnt", int'(dut.wr_cnt_q), (m_wcnt > 511) ? 511 : m_wcnt);
    checkOutput("rd_cnt", int'(dut.rd_cnt_q), m_reads % m_len);
    checkOutput("line_len", int'(dut.line_len_q), m_len);
  endtask

  task automatic driveCycle(input logic hs, input logic [5:0] pix, input logic en_v,
                            input logic vs_v, input logic rst_v);
    @(negedge clk28);
    compareAll();
    rst_n    = rst_v;
    ck14     = (gcyc % 2 == 0);
    ck7      = (gcyc % 4 == 0);
    hsync_in = hs;
    {g_in, r_in, b_in} = pix;
    en       = en_v;
    vsync_in = vs_v;
    gcyc++;
    if (!rst_v) modelReset();
    else        modelStep();
    if (!rst_v) begin
      #1;
      checkOutput("rst_rgb", int'({g, r, b}), 0);
      checkOutput("rst_hsync", int'(hsync), 1);
      checkOutput("rst_vsync", int'(vsync), 1);
    end
  endtask

  // One source line of ncyc clocks; hsync_in falls at its first clock.
  task automatic applyStimulus(input int ncyc, input bit en_v, input int flip_at,
                               input bit rand_pix, input int rst_at, input int rst_len);
    int idx = 0;
    logic [5:0] pix = 6'd0;
    logic vs  = vsync_in;
    logic env = en_v;
    logic rstv;
    for (int c = 0; c < ncyc; c++) begin
      if (gcyc % 4 == 0) begin
        pix = rand_pix ? 6'($urandom) : 6'(idx % 64);
        idx++;
      end
      if (c == flip_at) env = ~env;
      if (c == 100) vs = 1'($urandom);
      rstv = !(rst_at >= 0 && c >= rst_at && c < rst_at + rst_len);
      driveCycle((c >= 64) ? 1'b1 : 1'b0, pix, env, vs, rstv);
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 512; j++)
        mem[i][j] = -1;
    modelReset();
    rst_n = 1'b0; en = 1'b0; ck7 = 1'b0; ck14 = 1'b0;
    hsync_in = 1'b1; vsync_in = 1'b1;
    r_in = 2'd0; g_in = 2'd0; b_in = 2'd0;

    for (int i = 0; i < 3; i++) driveCycle(1'b1, 6'd0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) driveCycle(1'b1, 6'd0, 1'b0, 1'b1, 1'b1);

    // 448-pixel lines, pixel = index mod 64
    for (int i = 0; i < 3; i++) applyStimulus(4*448, 1'b1, -1, 1'b0, -1, 0);
    // 456 then 448 with random pixels
    applyStimulus(4*456, 1'b1, -1, 1'b1, -1, 0);
    applyStimulus(4*448, 1'b1, -1, 1'b1, -1, 0);
    applyStimulus(4*448, 1'b1, -1, 1'b1, -1, 0);
    // saturating long line, then a too-short line
    applyStimulus(4*600, 1'b1, -1, 1'b1, -1, 0);
    applyStimulus(4*30,  1'b1, -1, 1'b1, -1, 0);
    applyStimulus(4*448, 1'b1, -1, 1'b1, -1, 0);
    applyStimulus(4*448, 1'b1, -1, 1'b1, -1, 0);
    // line starts off the pixel strobe, then realigned
    applyStimulus(4*448+1, 1'b1, -1, 1'b1, -1, 0);
    applyStimulus(4*448+3, 1'b1, -1, 1'b1, -1, 0);
    applyStimulus(4*448,   1'b1, -1, 1'b1, -1, 0);
    // en dropped mid-line
    applyStimulus(4*448, 1'b1, 800, 1'b1, -1, 0);
    applyStimulus(4*448, 1'b0, -1, 1'b1, -1, 0);
    applyStimulus(4*448, 1'b0, -1, 1'b1, -1, 0);
    // back to doubling, then reset pulsed near the end of a line
    applyStimulus(4*448, 1'b1, -1, 1'b1, -1, 0);
    applyStimulus(4*448, 1'b1, -1, 1'b1, 4*448-3, 2);
    applyStimulus(4*448, 1'b1, -1, 1'b1, -1, 0);
    applyStimulus(4*448, 1'b1, -1, 1'b1, -1, 0);
    for (int i = 0; i < 4; i++) driveCycle(1'b1, 6'd0, 1'b1, 1'b1, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
